mem_arbiter: RTL
================

# mem_arbiter

Line-burst memory arbiter below `cpu_interface`: accepts I-cache refill and D-cache refill/writeback requests, serialises them onto a single-port word-addressed backing RAM, and returns refill words one per cycle. It is the only master of the backing RAM and turns each cache miss into a fixed-length burst of `LINE_WORDS` words.

## Interface
- `ADDR_W`, 30, word-address width.
- `DATA_W`, 32, data width.
- `LINE_WORDS`, 8, words per cache line (power of two, ≥2).
- `MEM_LAT`, 2, RAM read latency in cycles (≥1).
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ic_req`  in  1  I-cache refill request, held until `ic_done`.
- `ic_addr`  in  ADDR_W  refill word address; low offset bits ignored.
- `ic_rvalid`  out  1  refill word valid.
- `ic_done`  out  1  one-cycle pulse, burst complete.
- `dc_req`  in  1  D-cache request, held until `dc_done`.
- `dc_we`  in  1  1 = writeback, 0 = refill; stable while `dc_req`.
- `dc_addr`  in  ADDR_W  line word address; low offset bits ignored.
- `dc_wdata`  in  DATA_W  writeback word, consumed when `dc_wready`.
- `dc_wready`  out  1  current `dc_wdata` written this cycle.
- `dc_rvalid`  out  1  refill word valid.
- `dc_done`  out  1  one-cycle pulse, burst complete.
- `rdata`  out  DATA_W  refill word (shared, qualified by `*_rvalid`).
- `ridx`  out  log2(LINE_WORDS)  offset of `rdata` within line.
- `mem_en`, `mem_we`  out  1  RAM enable / write enable.
- `mem_addr`  out  ADDR_W  RAM word address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, valid `MEM_LAT` cycles after read enable.

## Operation
- States: IDLE, IC_RD, DC_RD, DC_WR.
- IDLE: sample requests; winner latches line base (`addr` with low log2(LINE_WORDS) bits cleared) and enters its state next cycle.
- Arbitration (default): `dc_req` beats `ic_req`.
- Read burst: issue counter drives `mem_en=1`, `mem_we=0`, `mem_addr=base+i` for i=0..LINE_WORDS-1 on consecutive cycles; receive counter asserts requester's `rvalid` with `rdata=mem_rdata`, `ridx=i`, in order 0..LINE_WORDS-1.
- Writeback burst: `mem_en=1`, `mem_we=1`, `mem_addr=base+i`, `mem_wdata=dc_wdata`, `dc_wready=1` for i=0..LINE_WORDS-1; the cache advances its word on each `dc_wready`.
- `*_done` pulses with last word (last `rvalid` or last `dc_wready`); return to IDLE next cycle.
- Request dropped mid-burst: illegal; burst completes regardless.
- Offset arithmetic wraps nothing: base+i never carries out of the line.

## Timing
- Reset (asserted any time, including mid-burst): state IDLE, counters 0, every output 0; burst abandoned, caller must re-request.
- Grant latency: request seen in IDLE at cycle T → first `mem_en` at T+1.
- Read: `mem_en` T+1..T+LINE_WORDS; `rvalid` T+1+MEM_LAT..T+MEM_LAT+LINE_WORDS; `done` at T+MEM_LAT+LINE_WORDS.
- Writeback: `dc_wready`/`mem_we` T+1..T+LINE_WORDS; `dc_done` at T+LINE_WORDS.
- Minimum one IDLE cycle between bursts; back-to-back requests resolved at that IDLE cycle.
- `rvalid` never asserted for both requesters in one cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin; one-bit pointer, last-served requester loses ties; pointer resets to favour D-cache. Bound: neither requester waits more than one foreign burst.
- Undefined: fixed D-cache priority as above; I-cache may starve under continuous D-cache traffic.

## Structure
- `mem_arb_pkg`: state enum, `LINE_OFF_W = $clog2(LINE_WORDS)`, line-base mask function.
- One sub-module `mem_burst_ctr`: issue/receive counter pair with `MEM_LAT` valid shift register; instantiated once, shared by all states.

## Test plan
- Reset: `rst=0` mid IC_RD burst → all outputs 0 next edge-independent; after release `ic_req` with `ic_addr=0x11` → burst to 0x10..0x17, `ic_done` at T+MEM_LAT+8.
- D writeback `dc_addr=0x20`, words 0x40..0x47 → RAM 0x20..0x27 hold 0x40..0x47, `dc_done` at T+8.
- D refill `dc_addr=0x25` after above → `rdata` 0x40..0x47, `ridx` 0..7, base 0x20.
- Simultaneous `ic_req`(0x10) and `dc_req` refill(0x820): default → D burst first, I burst starts after one IDLE cycle.
- `MEM_ARB_RR_EN`, both requesting continuously → grants alternate D, I, D, I.
- Writeback 0x1020 then refill 0x1020 → refill returns the written words exactly.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the line-burst memory arbiter and its burst counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IC_RD = 2'd1,
        DC_RD = 2'd2,
        DC_WR = 2'd3
    } arb_state_e;

    localparam int ADDR_W_DEF     = 30;
    localparam int DATA_W_DEF     = 32;
    localparam int LINE_WORDS_DEF = 8;
    localparam int MEM_LAT_DEF    = 2;
    localparam int LINE_OFF_W     = $clog2(LINE_WORDS_DEF);

    // Clears the in-line offset bits so a miss address becomes the line base.
    function automatic logic [63:0] line_base(input logic [63:0] addr,
                                              input int          off_w = LINE_OFF_W);
        return addr & ~((64'd1 << off_w) - 64'd1);
    endfunction

endpackage

// File: rtl/mem_burst_ctr.sv
// Issue/receive counter pair for one line burst, with a MEM_LAT-deep read-valid pipe
// that lines the receive side up with the RAM read latency.
module mem_burst_ctr
    import mem_arb_pkg::*;
#(
    parameter int  LINE_WORDS = LINE_WORDS_DEF,
    parameter int  MEM_LAT    = MEM_LAT_DEF,
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             issue,
    input  logic             issue_rd,
    output logic             issue_busy,
    output logic [OFF_W-1:0] issue_idx,
    output logic             issue_last,
    output logic             rx_valid,
    output logic [OFF_W-1:0] rx_idx,
    output logic             rx_last
);

    // One extra bit so "all words issued" is distinguishable from index 0.
    logic [OFF_W:0]     issue_cnt;
    logic [OFF_W-1:0]   rx_cnt;
    logic [MEM_LAT-1:0] rd_pipe;

    assign issue_busy = ~issue_cnt[OFF_W];
    assign issue_idx  = issue_cnt[OFF_W-1:0];
    assign issue_last = issue && issue_busy && (issue_idx == OFF_W'(LINE_WORDS - 1));

    assign rx_valid = rd_pipe[MEM_LAT-1];
    assign rx_idx   = rx_cnt;
    assign rx_last  = rx_valid && (rx_cnt == OFF_W'(LINE_WORDS - 1));

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt <= '0;
            rx_cnt    <= '0;
            rd_pipe   <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | MEM_LAT'(issue && issue_rd);
            if (clear) begin
                issue_cnt <= '0;
                rx_cnt    <= '0;
            end else begin
                if (issue && issue_busy) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (rx_valid) begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache refills and D-cache refills/writebacks onto one backing RAM as line bursts.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the D-cache has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  ADDR_W     = ADDR_W_DEF,
    parameter int  DATA_W     = DATA_W_DEF,
    parameter int  LINE_WORDS = LINE_WORDS_DEF,
    parameter int  MEM_LAT    = MEM_LAT_DEF,
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_rvalid,
    output logic              ic_done,

    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wready,
    output logic              dc_rvalid,
    output logic              dc_done,

    output logic [DATA_W-1:0] rdata,
    output logic [OFF_W-1:0]  ridx,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic              grant_dc, grant_ic;
    logic              issue, issue_rd;
    logic              issue_busy, issue_last;
    logic [OFF_W-1:0]  issue_idx;
    logic              rx_valid, rx_last;
    logic [OFF_W-1:0]  rx_idx;

`ifdef MEM_ARB_RR_EN
    // Set when the D-cache should win the next tie; cleared once it has been served.
    logic prefer_dc;

    assign grant_dc = dc_req && (!ic_req || prefer_dc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prefer_dc <= 1'b1;
        end else if (state == IDLE) begin
            if (grant_dc) begin
                prefer_dc <= 1'b0;
            end else if (ic_req) begin
                prefer_dc <= 1'b1;
            end
        end
    end
`else
    assign grant_dc = dc_req;
`endif

    assign grant_ic = ic_req && !grant_dc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (grant_dc || grant_ic)) begin
                base <= ADDR_W'(line_base(64'(grant_dc ? dc_addr : ic_addr), OFF_W));
            end
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        issue_rd  = 1'b0;
        dc_wready = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_dc) begin
                    state_nxt = dc_we ? DC_WR : DC_RD;
                end else if (grant_ic) begin
                    state_nxt = IC_RD;
                end
            end
            IC_RD, DC_RD: begin
                issue    = issue_busy;
                issue_rd = 1'b1;
                if (rx_last) begin
                    state_nxt = IDLE;
                end
            end
            DC_WR: begin
                issue     = issue_busy;
                dc_wready = issue_busy;
                if (issue_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    mem_burst_ctr #(
        .LINE_WORDS (LINE_WORDS),
        .MEM_LAT    (MEM_LAT)
    ) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == IDLE),
        .issue      (issue),
        .issue_rd   (issue_rd),
        .issue_busy (issue_busy),
        .issue_idx  (issue_idx),
        .issue_last (issue_last),
        .rx_valid   (rx_valid),
        .rx_idx     (rx_idx),
        .rx_last    (rx_last)
    );

    // Data/address outputs are gated to zero outside their qualifying cycles.
    assign mem_en    = issue;
    assign mem_we    = issue && !issue_rd;
    assign mem_addr  = issue ? (base | ADDR_W'(issue_idx)) : '0;
    assign mem_wdata = mem_we ? dc_wdata : '0;

    assign ic_rvalid = rx_valid && (state == IC_RD);
    assign dc_rvalid = rx_valid && (state == DC_RD);
    assign rdata     = rx_valid ? mem_rdata : '0;
    assign ridx      = rx_valid ? rx_idx : '0;

    assign ic_done = (state == IC_RD) && rx_last;
    assign dc_done = ((state == DC_RD) && rx_last) || ((state == DC_WR) && issue_last);

endmodule
